// File: rtl/mem_loader.sv
// mem_loader: streams len words from a valid/ready source into a synchronous
// memory starting at base_addr, with registered memory-side outputs.
// Optional readback verification is built when MEM_LOADER_VERIFY_EN is defined:
// the written words are read back, XOR-summed and compared against the XOR of
// the accepted input words; a mismatch raises a sticky error.
module mem_loader #(
  parameter int ADDR = 16,
  parameter int WORD = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [ADDR-1:0] base_addr,
  input  logic [ADDR-1:0] len,
  input  logic            in_valid,
  input  logic [WORD-1:0] in_data,
  output logic            in_ready,
  output logic [ADDR-1:0] mem_addr,
  output logic            mem_write,
  output logic [WORD-1:0] mem_in,
  input  logic [WORD-1:0] mem_out,
  output logic            busy,
  output logic            done,
  output logic            error
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    VREAD,
    VDRAIN,
    DONE
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [ADDR-1:0] base_q;
  logic [ADDR-1:0] len_q;
  logic [ADDR-1:0] idx;
  logic            accept;
  logic            hs;
  logic            last_word;

  assign accept    = (state == IDLE) && start;
  assign hs        = (state == WRITE) && in_valid;
  assign last_word = (idx == (len_q - ADDR'(1)));

`ifdef MEM_LOADER_VERIFY_EN
  logic [ADDR-1:0] rd_idx;
  logic            rd_pres;
  logic            rd_dval;
  logic [WORD-1:0] wr_sum;
  logic [WORD-1:0] rd_sum;
  logic [WORD-1:0] rd_sum_next;
  logic            err_q;

  // mem_out carries read data the cycle after its address was presented
  assign rd_sum_next = rd_dval ? (rd_sum ^ mem_out) : rd_sum;
  assign error       = err_q;
`else
  logic            mem_out_unused;

  assign mem_out_unused = ^mem_out;
  assign error          = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and state-derived handshake/status outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (len == '0) ? DONE : WRITE;
        end
      end
      WRITE: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && last_word) begin
`ifdef MEM_LOADER_VERIFY_EN
          state_next = VREAD;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef MEM_LOADER_VERIFY_EN
      VREAD: begin
        busy = 1'b1;
        // leave once the last read address is on the bus
        if (rd_idx == len_q) begin
          state_next = VDRAIN;
        end
      end
      VDRAIN: begin
        busy       = 1'b1;
        state_next = DONE;
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Load parameters, word index and registered memory port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q    <= '0;
      len_q     <= '0;
      idx       <= '0;
      mem_addr  <= '0;
      mem_write <= 1'b0;
      mem_in    <= '0;
    end else begin
      mem_write <= 1'b0;
      if (accept) begin
        base_q <= base_addr;
        len_q  <= len;
        idx    <= '0;
      end
      if (hs) begin
        mem_write <= 1'b1;
        mem_addr  <= base_q + idx;
        mem_in    <= in_data;
        idx       <= idx + ADDR'(1);
      end
`ifdef MEM_LOADER_VERIFY_EN
      else if ((state == VREAD) && (rd_idx != len_q)) begin
        mem_addr <= base_q + rd_idx;
      end
`endif
    end
  end

  // Completion pulse, one cycle after the DONE state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done <= 1'b0;
    end else begin
      done <= (state == DONE);
    end
  end

`ifdef MEM_LOADER_VERIFY_EN
  // Checksums, readback pipeline flags and sticky verify error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_idx  <= '0;
      rd_pres <= 1'b0;
      rd_dval <= 1'b0;
      wr_sum  <= '0;
      rd_sum  <= '0;
      err_q   <= 1'b0;
    end else begin
      rd_pres <= (state == VREAD) && (rd_idx != len_q);
      rd_dval <= rd_pres;
      if (accept) begin
        rd_idx <= '0;
        wr_sum <= '0;
        rd_sum <= '0;
        err_q  <= 1'b0;
      end
      if (hs) begin
        wr_sum <= wr_sum ^ in_data;
      end
      if (state == VREAD) begin
        rd_sum <= rd_sum_next;
        if (rd_idx != len_q) begin
          rd_idx <= rd_idx + ADDR'(1);
        end
      end
      if (state == VDRAIN) begin
        rd_sum <= rd_sum_next;
        err_q  <= (rd_sum_next != wr_sum);
      end
    end
  end
`endif

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter ADDR, 16, memory address width in bits.
REQ-002 Parameter WORD, 32, memory data width in bits.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-006 base_addr  input  ADDR  first memory address of the load; latched on accepted start.
REQ-007 len  input  ADDR  number of words to load; latched on accepted start; 0 means empty load.
REQ-008 in_valid  input  1  source has a word on in_data.
REQ-009 in_data  input  WORD  data word from source.
REQ-010 in_ready  output  1  loader accepts a word this cycle.
REQ-011 mem_addr  output  ADDR  memory address (A); registered.
REQ-012 mem_write  output  1  memory write enable (W); registered.
REQ-013 mem_in  output  WORD  memory write data (D); registered.
REQ-014 mem_out  input  WORD  memory read data (Q); valid one cycle after mem_addr is presented.
REQ-015 busy  output  1  load in progress.
REQ-016 done  output  1  one-cycle pulse at load completion.
REQ-017 error  output  1  verify mismatch; sticky until next accepted start.

Function
- REQ-018 States: IDLE, WRITE, VREAD, VDRAIN, DONE; the module SHALL use exactly these.
- REQ-019 IDLE: in_ready=0, busy=0; start=1 latches base_addr and len, sets word index to 0, clears error and checksum; next state WRITE when len!=0, DONE when len==0.
- REQ-020 start outside IDLE SHALL be ignored.
- REQ-021 WRITE: in_ready=1, busy=1; on in_valid&in_ready at an edge, the next cycle SHALL show mem_write=1, mem_addr=base+index, mem_in=in_data (1-cycle latency); index increments; checksum ^= in_data.
- REQ-022 A cycle without handshake SHALL drive mem_write=0 the following cycle; mem_addr holds its last value.
- REQ-023 Address arithmetic SHALL wrap modulo 2^ADDR (base 16'hFFFF, len 2 -> addresses FFFF, 0000).
- REQ-024 On the handshake of word len-1, in_ready SHALL drop the next cycle; next state VREAD when VERIFY_EN is defined, otherwise DONE.
- REQ-025 VREAD: mem_write=0; mem_addr steps base..base+len-1, one per cycle; mem_out sampled one cycle after each address is presented and XORed into the readback sum.
- REQ-026 VDRAIN: one cycle to capture the final mem_out; then compare readback sum with write checksum, set error=1 on mismatch, go to DONE.
- REQ-027 DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- REQ-028 busy SHALL be 1 in WRITE, VREAD, VDRAIN, and 0 in IDLE and DONE.
- REQ-029 len is the full count; len=16'hFFFF writes 65535 words; 65536-word loads are not supported.

Reset
- REQ-030 reset=0 SHALL immediately force IDLE, with in_ready=0, mem_write=0, mem_addr=0, mem_in=0, busy=0, done=0, error=0, index=0, checksums=0.
- REQ-031 Reset mid-load SHALL abandon the load with no further memory write; already-written words stay in memory.

Configuration
- REQ-032 Macro MEM_LOADER_VERIFY_EN: defined -> VREAD/VDRAIN readback checksum verification per REQ-025/026.
- REQ-033 Without MEM_LOADER_VERIFY_EN: WRITE proceeds directly to DONE, the VREAD/VDRAIN logic and checksums are not built, and error is tied to 0.

Verification
- REQ-034 base=16'h0010, len=4, data 11111111,22222222,33333333,44444444 with in_valid held -> four consecutive mem_write cycles at 0010..0013; done pulses once; memory readback matches.
- REQ-035 Same load with in_valid low every other cycle -> mem_write only after handshakes; addresses contiguous; no dropped or duplicated words.
- REQ-036 base=16'hFFFE, len=3 -> writes at FFFE, FFFF, 0000.
- REQ-037 len=0 with start -> no mem_write; done pulses 2 cycles after start; busy never 1.
- REQ-038 With VERIFY_EN, bench corrupts memory word 0012 before readback -> error=1 with done; next start clears error.
- REQ-039 reset asserted after 2 of 4 words -> outputs at reset values within the same cycle; only 0010 and 0011 written; new start works normally.
